pq_ctrl: RTL
============

// Module: pq_ctrl
// PURPOSE
//  Command sequencer in front of the systolic priority-queue cell array.
//  - Accepts push / pop / drop requests on three valid/grant channels and arbitrates them round-robin.
//  - Issues exactly one command at a time to the head cell and waits for that cell's completion strobe.
//  - Returns a response, tracks occupancy and enforces full/empty protection.
// PARAMETERS
//  IW    4   ID width; ID 0 is reserved and means "empty slot".
//  DEPTH 8   number of cells in the array; occupancy limit.
//  TMO   15  maximum cycles spent in WAIT before a timeout error.
//  CW    $clog2(DEPTH+1)   occupancy counter width (derived, do not override).
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      asynchronous reset, active low
//  push_req_i     in   1      push request; held until granted
//  push_id_i      in   IW     ID to insert
//  push_gnt_o     out  1      one-cycle grant
//  pop_req_i      in   1      pop request; held until granted
//  pop_gnt_o      out  1      one-cycle grant
//  drop_req_i     in   1      drop request; held until granted
//  drop_id_i      in   IW     ID to remove
//  drop_gnt_o     out  1      one-cycle grant
//  rsp_vld_o      out  1      one-cycle response strobe
//  rsp_op_o       out  2      op_e of the completed command
//  rsp_id_o       out  IW     popped ID (pop); echoed ID (push/drop)
//  rsp_err_o      out  1      error: full, empty, ID 0, miss or timeout
//  arr_push_o     out  1      one-cycle push command to head cell
//  arr_pop_o      out  1      one-cycle pop command to head cell
//  arr_drop_o     out  1      one-cycle drop command to head cell
//  arr_id_o       out  IW     push ID, valid with arr_push_o
//  arr_drop_id_o  out  IW     drop ID, valid with arr_drop_o
//  arr_push_vld_i in   1      head cell push completion
//  arr_pop_vld_i  in   1      head cell pop completion
//  arr_pop_id_i   in   IW     popped ID, valid with arr_pop_vld_i
//  arr_drop_vld_i in   1      head cell drop completion
//  arr_drop_hit_i in   1      drop found its ID, valid with arr_drop_vld_i
//  count_o        out  CW     occupancy
//  full_o         out  1      count_o == DEPTH
//  empty_o        out  1      count_o == 0
//  busy_o         out  1      state != IDLE
//  proto_err_o    out  1      sticky: completion strobe seen for an op not in flight
// BEHAVIOUR
//  Reset values: all outputs 0 except empty_o = 1. State = IDLE, count = 0, RR pointer = PUSH.
//  Reset mid-operation discards the in-flight op with no response.
//  FSM states: IDLE, ISSUE, WAIT, RSP.
//  IDLE
//   - Round-robin over the asserted requests, order PUSH -> POP -> DROP.
//   - The pointer moves to one past the winner on every grant.
//   - The grant is asserted combinationally in IDLE; op and ID are latched.
//  Pre-check on grant (no array command; next state RSP with err = 1):
//   - push while full;
//   - push with ID 0;
//   - pop while empty;
//   - drop while empty;
//   - drop with ID 0.
//  Otherwise go to ISSUE.
//  ISSUE (1 cycle): pulse arr_push_o, arr_pop_o or arr_drop_o with the latched ID, then go to WAIT.
//  WAIT
//   - The timer counts from 0.
//   - When the matching *_vld_i arrives, update the count and go to RSP:
//     - push: count + 1;
//     - pop: count - 1 if arr_pop_id_i != 0, otherwise err;
//     - drop: count - 1 if hit, otherwise err (miss).
//   - If the timer reaches TMO, go to RSP with err = 1 and leave the count unchanged.
//  RSP (1 cycle): rsp_vld_o = 1, then return to IDLE. No grant is issued in RSP.
//  Latency: grant at cycle t; array command at t+1; completion at t+1+k with k >= 1; response at t+2+k.
//  Pre-check errors respond at t+1.
//  Completion strobes outside WAIT, or for a different op, are ignored and set proto_err_o.
//  Requests arriving while busy_o = 1 wait; they are never dropped.
//  full_o, empty_o and count_o are registered and update in the cycle after the completion.
//  The count saturates at 0 and at DEPTH. The timer stops at TMO and clears on leaving WAIT.
// STRUCTURE
//  pq_pkg: typedef enum logic[1:0] op_e {OP_NONE, OP_PUSH, OP_POP, OP_DROP}; ctrl state enum; IW default.
//  Sub-module pq_rr_arb3: 3-way round-robin arbiter (req[2:0], advance, gnt[2:0]; pointer register).
//  Everything else is a single FSM plus count, timer and latch registers in this module.
// TESTING
//  1. Reset, push_id 5, array push_vld after 1 cycle -> arr_push_o with id 5; rsp {PUSH, 5, err 0}; count 1.
//  2. Count = 1, pop, arr_pop_vld with id 5 -> rsp {POP, 5, err 0}; count 0; empty_o = 1.
//  3. push, pop and drop requested in the same cycle from IDLE -> grants in order push, pop, drop, one per command; none lost.
//  4. DEPTH pushes, then push id 3 -> immediate rsp err 1 at t+1; no arr_push_o; count stays 8.
//  5. Drop id 9 with arr_drop_hit 0 -> rsp {DROP, 9, err 1}; count unchanged.
//  6. Pop with no arr_pop_vld -> rsp err 1 at TMO; count unchanged. Stray arr_push_vld in IDLE -> proto_err_o = 1 until reset.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue command sequencer.
// Op codes, controller state encoding and default ID width.
package pq_pkg;

  localparam int IW_DEF = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_DROP
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RSP
  } st_e;

endpackage

// File: rtl/pq_rr_arb3.sv
// 3-way round-robin arbiter; bit 0 push, bit 1 pop, bit 2 drop.
// Ports: req_i requests, adv_i moves pointer past winner, gnt_o one-hot.
module pq_rr_arb3 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       adv_i,
  output logic [2:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_o = 3'b000;
    case (ptr_q)
      2'd0: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
      2'd1: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      default: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      unique case (1'b1)
        gnt_o[0]: ptr_d = 2'd1;
        gnt_o[1]: ptr_d = 2'd2;
        gnt_o[2]: ptr_d = 2'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 2'd0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pq_ctrl.sv
// Command sequencer for the systolic priority-queue array: arbitrates
// push/pop/drop, issues one head-cell command at a time, tracks occupancy.
module pq_ctrl
  import pq_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 8,
  parameter int TMO   = 15,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_req_i,
  input  logic [IW-1:0] push_id_i,
  output logic          push_gnt_o,
  input  logic          pop_req_i,
  output logic          pop_gnt_o,
  input  logic          drop_req_i,
  input  logic [IW-1:0] drop_id_i,
  output logic          drop_gnt_o,
  output logic          rsp_vld_o,
  output logic [1:0]    rsp_op_o,
  output logic [IW-1:0] rsp_id_o,
  output logic          rsp_err_o,
  output logic          arr_push_o,
  output logic          arr_pop_o,
  output logic          arr_drop_o,
  output logic [IW-1:0] arr_id_o,
  output logic [IW-1:0] arr_drop_id_o,
  input  logic          arr_push_vld_i,
  input  logic          arr_pop_vld_i,
  input  logic [IW-1:0] arr_pop_id_i,
  input  logic          arr_drop_vld_i,
  input  logic          arr_drop_hit_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          busy_o,
  output logic          proto_err_o
);

  localparam int TW = $clog2(TMO + 1);

  st_e           state_q, state_d;
  op_e           op_q, op_d;
  logic [IW-1:0] id_q, id_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          proto_q, proto_d;

  logic [2:0] req, gnt;
  logic       idle, in_wait, full, empty;
  logic       push_done, pop_done, drop_done, stray;

  assign idle    = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT);
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign req     = {drop_req_i, pop_req_i, push_req_i} & {3{idle}};

  pq_rr_arb3 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req),
    .adv_i  (|gnt),
    .gnt_o  (gnt)
  );

  assign push_done = in_wait && op_q == OP_PUSH && arr_push_vld_i;
  assign pop_done  = in_wait && op_q == OP_POP  && arr_pop_vld_i;
  assign drop_done = in_wait && op_q == OP_DROP && arr_drop_vld_i;

  // Any strobe that is not the completion of the op in flight.
  assign stray = (arr_push_vld_i && !push_done)
              || (arr_pop_vld_i  && !pop_done)
              || (arr_drop_vld_i && !drop_done);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmr_d   = '0;
    proto_d = proto_q | stray;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          unique case (1'b1)
            gnt[0]: begin
              op_d  = OP_PUSH;
              id_d  = push_id_i;
              err_d = full || (push_id_i == '0);
            end
            gnt[1]: begin
              op_d  = OP_POP;
              id_d  = '0;
              err_d = empty;
            end
            gnt[2]: begin
              op_d  = OP_DROP;
              id_d  = drop_id_i;
              err_d = empty || (drop_id_i == '0);
            end
            default: ;
          endcase
          state_d = err_d ? ST_RSP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (push_done) begin
          if (!full) cnt_d = cnt_q + CW'(1);
          state_d = ST_RSP;
        end else if (pop_done) begin
          id_d = arr_pop_id_i;
          if (arr_pop_id_i == '0) err_d = 1'b1;
          else if (!empty)        cnt_d = cnt_q - CW'(1);
          state_d = ST_RSP;
        end else if (drop_done) begin
          if (!arr_drop_hit_i) err_d = 1'b1;
          else if (!empty)     cnt_d = cnt_q - CW'(1);
          state_d = ST_RSP;
        end else if (tmr_q == TW'(TMO)) begin
          err_d   = 1'b1;
          state_d = ST_RSP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_RSP: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      id_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      proto_q <= proto_d;
    end
  end

  assign push_gnt_o = gnt[0];
  assign pop_gnt_o  = gnt[1];
  assign drop_gnt_o = gnt[2];

  assign arr_push_o    = (state_q == ST_ISSUE) && op_q == OP_PUSH;
  assign arr_pop_o     = (state_q == ST_ISSUE) && op_q == OP_POP;
  assign arr_drop_o    = (state_q == ST_ISSUE) && op_q == OP_DROP;
  assign arr_id_o      = arr_push_o ? id_q : '0;
  assign arr_drop_id_o = arr_drop_o ? id_q : '0;

  assign rsp_vld_o = (state_q == ST_RSP);
  assign rsp_op_o  = rsp_vld_o ? op_q : OP_NONE;
  assign rsp_id_o  = rsp_vld_o ? id_q : '0;
  assign rsp_err_o = rsp_vld_o && err_q;

  assign count_o     = cnt_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign busy_o      = !idle;
  assign proto_err_o = proto_q;

endmodule
